// File: rtl/alu_fu_pipe_if.sv
// Issue/CDB bundle of the integer ALU functional unit.
// Optional macro ALU_FU_BRANCH_EN adds the cdb_br_taken signal.
interface alu_fu_pipe_if #(
  parameter int ROB_DEPTH = 8,
  parameter int XLEN      = 32,
  parameter int OUT_DEPTH = 2
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  // Reservation station -> unit
  logic             issue_valid;
  logic             issue_ready;
  logic [31:0]      issue_instr;
  logic [XLEN-1:0]  issue_data_A;
  logic [XLEN-1:0]  issue_data_B;
  logic [TAG_W-1:0] issue_tag;
  logic             flush;

  // Unit -> CDB arbiter
  logic             cdb_valid;
  logic             cdb_grant;
  logic [XLEN-1:0]  cdb_result;
  logic [TAG_W-1:0] cdb_tag;
  logic             cdb_illegal;
  logic [CNT_W-1:0] occupancy;
`ifdef ALU_FU_BRANCH_EN
  logic             cdb_br_taken;
`endif

  modport master (
    output issue_valid, issue_instr, issue_data_A, issue_data_B, issue_tag,
    output flush, cdb_grant,
    input  issue_ready, cdb_valid, cdb_result, cdb_tag, cdb_illegal, occupancy
`ifdef ALU_FU_BRANCH_EN
    , input cdb_br_taken
`endif
  );

  modport slave (
    input  issue_valid, issue_instr, issue_data_A, issue_data_B, issue_tag,
    input  flush, cdb_grant,
    output issue_ready, cdb_valid, cdb_result, cdb_tag, cdb_illegal, occupancy
`ifdef ALU_FU_BRANCH_EN
    , output cdb_br_taken
`endif
  );
endinterface

// File: rtl/alu_fu_pipe.sv
// Registered RV32I integer ALU functional unit (LUI/AUIPC/OP-IMM/OP).
// Results queue in a small circular buffer and are held on the CDB until granted.
// Optional macro ALU_FU_BRANCH_EN makes BRANCH ops legal and drives cdb_br_taken.
module alu_fu_pipe #(
  parameter int ROB_DEPTH = 8,
  parameter int XLEN      = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_fu_pipe_if.slave fu
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  // Instruction field decode
  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic            bit30;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            unused_instr;

  assign opc          = fu.issue_instr[6:0];
  assign funct3       = fu.issue_instr[14:12];
  assign bit30        = fu.issue_instr[30];
  assign op_a         = fu.issue_data_A;
  assign op_b         = fu.issue_data_B;
  assign shamt        = op_b[SH_W-1:0];
  assign unused_instr = ^{fu.issue_instr[31], fu.issue_instr[29:15], fu.issue_instr[11:7]};

  // Shared comparison results
  logic lt_s;
  logic lt_u;
  logic eq_ab;

  assign lt_s  = $signed(op_a) < $signed(op_b);
  assign lt_u  = op_a < op_b;
  assign eq_ab = op_a == op_b;

  // Result computed from the issue inputs, written at the accepting edge
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;

  // Integer/OP-IMM/OP result and illegal-op detection
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (opc)
      OPC_LUI:   alu_res = op_b;
      OPC_AUIPC: alu_res = op_a + op_b;
      OPC_OP_IMM, OPC_OP: begin
        case (funct3)
          3'b000: alu_res = (opc == OPC_OP && bit30) ? (op_a - op_b) : (op_a + op_b);
          3'b001: alu_res = op_a << shamt;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
          3'b100: alu_res = op_a ^ op_b;
          3'b101: alu_res = bit30 ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
          3'b110: alu_res = op_a | op_b;
          default: alu_res = op_a & op_b;
        endcase
      end
`ifdef ALU_FU_BRANCH_EN
      OPC_BRANCH: begin
        case (funct3)
          3'b000: alu_res = {{(XLEN-1){1'b0}}, eq_ab};
          3'b001: alu_res = {{(XLEN-1){1'b0}}, !eq_ab};
          3'b100: alu_res = {{(XLEN-1){1'b0}}, lt_s};
          3'b101: alu_res = {{(XLEN-1){1'b0}}, !lt_s};
          3'b110: alu_res = {{(XLEN-1){1'b0}}, lt_u};
          3'b111: alu_res = {{(XLEN-1){1'b0}}, !lt_u};
          default: alu_ill = 1'b1;
        endcase
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifndef ALU_FU_BRANCH_EN
  logic unused_cmp;
  assign unused_cmp = eq_ab;
`endif

  // Result queue storage and pointers
  logic [XLEN-1:0]  q_res [OUT_DEPTH];
  logic [TAG_W-1:0] q_tag [OUT_DEPTH];
  logic             q_ill [OUT_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic head_valid;
  logic pop_req;
  logic push;
  logic pop;

  assign head_valid     = count != '0;
  assign pop_req        = head_valid & fu.cdb_grant;
  // A same-cycle pop frees a slot, so a full queue can still accept
  assign fu.issue_ready = (count < CNT_W'(OUT_DEPTH)) | pop_req;
  assign push           = fu.issue_valid & fu.issue_ready & !fu.flush;
  assign pop            = pop_req & !fu.flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUT_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Queue pointers and occupancy; flush overrides any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (fu.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue entry writes at the tail on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        q_res[i] <= '0;
        q_tag[i] <= '0;
        q_ill[i] <= 1'b0;
      end
    end else if (push) begin
      q_res[tail] <= alu_ill ? '0 : alu_res;
      q_tag[tail] <= fu.issue_tag;
      q_ill[tail] <= alu_ill;
    end
  end

  // Head presentation, forced to zero while the queue is empty
  assign fu.cdb_valid   = head_valid;
  assign fu.cdb_result  = head_valid ? q_res[head] : '0;
  assign fu.cdb_tag     = head_valid ? q_tag[head] : '0;
  assign fu.cdb_illegal = head_valid ? q_ill[head] : 1'b0;
  assign fu.occupancy   = count;
`ifdef ALU_FU_BRANCH_EN
  assign fu.cdb_br_taken = head_valid ? q_res[head][0] : 1'b0;
`endif

endmodule

// File: tb/tb_alu_fu_pipe.sv
// Directed, table-driven bench for alu_fu_pipe (default parameters).
module tb_alu_fu_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_fu_pipe_if #(.ROB_DEPTH(8), .XLEN(32), .OUT_DEPTH(2)) bus ();

  alu_fu_pipe #(.ROB_DEPTH(8), .XLEN(32), .OUT_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fu    (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  tag;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
    return {1'b0, b30, 15'b0, f3, 5'b0, opc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic add(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] tag, input logic [31:0] expv, input logic ill);
    vec_t v;
    v.instr = instr; v.a = a; v.b = b; v.tag = tag; v.exp = expv; v.ill = ill;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] tag);
    bus.issue_valid  = 1'b1;
    bus.issue_instr  = instr;
    bus.issue_data_A = a;
    bus.issue_data_B = b;
    bus.issue_tag    = tag;
  endtask

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011;

  initial begin
    bus.issue_valid = 1'b0; bus.issue_instr = '0; bus.issue_data_A = '0;
    bus.issue_data_B = '0; bus.issue_tag = '0; bus.flush = 1'b0; bus.cdb_grant = 1'b0;

    add(mk(OP, 3'b000, 1'b0), 32'd5, 32'd7, 3'd3, 32'd12, 1'b0);
    add(mk(OP, 3'b000, 1'b1), 32'd3, 32'd5, 3'd1, 32'hFFFF_FFFE, 1'b0);
    add(mk(OP, 3'b101, 1'b1), 32'h8000_0000, 32'd4, 3'd2, 32'hF800_0000, 1'b0);
    add(mk(OP, 3'b101, 1'b0), 32'h8000_0000, 32'd4, 3'd4, 32'h0800_0000, 1'b0);
    add(mk(OP, 3'b010, 1'b0), 32'hFFFF_FFFF, 32'd1, 3'd5, 32'd1, 1'b0);
    add(mk(OP, 3'b011, 1'b0), 32'hFFFF_FFFF, 32'd1, 3'd6, 32'd0, 1'b0);
    add(mk(7'b0110111, 3'b000, 1'b0), 32'hDEAD, 32'h1234_5000, 3'd7, 32'h1234_5000, 1'b0);
    add(mk(7'b0010111, 3'b000, 1'b0), 32'h100, 32'h2000, 3'd0, 32'h2100, 1'b0);
    add(mk(OPI, 3'b001, 1'b0), 32'd1, 32'd35, 3'd1, 32'd8, 1'b0);
    add(mk(OPI, 3'b100, 1'b0), 32'hF0F0, 32'h0FF0, 3'd2, 32'hFF00, 1'b0);
    add(mk(OPI, 3'b110, 1'b0), 32'h0F0, 32'h00F, 3'd3, 32'hFF, 1'b0);
    add(mk(OPI, 3'b111, 1'b0), 32'hFF, 32'h0F, 3'd4, 32'h0F, 1'b0);
    add(mk(OPI, 3'b000, 1'b1), 32'd10, 32'd3, 3'd6, 32'd13, 1'b0);
    add(mk(7'b0000011, 3'b010, 1'b0), 32'd9, 32'd9, 3'd5, 32'd0, 1'b1);
`ifdef ALU_FU_BRANCH_EN
    add(mk(7'b1100011, 3'b110, 1'b0), 32'd1, 32'hFFFF_FFFF, 3'd2, 32'd1, 1'b0);
    add(mk(7'b1100011, 3'b101, 1'b0), 32'hFFFF_FFFF, 32'd1, 3'd3, 32'd0, 1'b0);
    add(mk(7'b1100011, 3'b010, 1'b0), 32'd1, 32'd1, 3'd4, 32'd0, 1'b1);
`else
    add(mk(7'b1100011, 3'b110, 1'b0), 32'd1, 32'hFFFF_FFFF, 3'd2, 32'd0, 1'b1);
`endif

    // Reset state
    #12;
    chk("rst_valid", {31'b0, bus.cdb_valid}, 32'd0);
    chk("rst_occ", {30'b0, bus.occupancy}, 32'd0);
    chk("rst_result", bus.cdb_result, 32'd0);
    chk("rst_tag", {29'b0, bus.cdb_tag}, 32'd0);
    chk("rst_illegal", {31'b0, bus.cdb_illegal}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", {31'b0, bus.issue_ready}, 32'd1);

    // Table: one op per cycle with grant held, each result visible one edge later
    bus.cdb_grant = 1'b1;
    foreach (vt[i]) begin
      drive(vt[i].instr, vt[i].a, vt[i].b, vt[i].tag);
      chk($sformatf("v%0d_ready", i), {31'b0, bus.issue_ready}, 32'd1);
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, bus.cdb_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), bus.cdb_result, vt[i].exp);
      chk($sformatf("v%0d_tag", i), {29'b0, bus.cdb_tag}, {29'b0, vt[i].tag});
      chk($sformatf("v%0d_illegal", i), {31'b0, bus.cdb_illegal}, {31'b0, vt[i].ill});
      chk($sformatf("v%0d_occ", i), {30'b0, bus.occupancy}, 32'd1);
`ifdef ALU_FU_BRANCH_EN
      chk($sformatf("v%0d_brtaken", i), {31'b0, bus.cdb_br_taken}, {31'b0, vt[i].exp[0]});
`endif
    end
    bus.issue_valid = 1'b0;
    step();
    chk("drain_occ", {30'b0, bus.occupancy}, 32'd0);
    chk("drain_valid", {31'b0, bus.cdb_valid}, 32'd0);
    chk("drain_result", bus.cdb_result, 32'd0);

    // Backpressure, full-queue push with pop, pointer wrap
    bus.cdb_grant = 1'b0;
    drive(mk(OP, 3'b000, 1'b0), 32'd1, 32'd1, 3'd1);
    step();
    chk("bp_occ1", {30'b0, bus.occupancy}, 32'd1);
    chk("bp_ready1", {31'b0, bus.issue_ready}, 32'd1);
    drive(mk(OP, 3'b000, 1'b0), 32'd1, 32'd2, 3'd2);
    step();
    chk("bp_occ2", {30'b0, bus.occupancy}, 32'd2);
    chk("bp_ready_full", {31'b0, bus.issue_ready}, 32'd0);
    drive(mk(OP, 3'b000, 1'b0), 32'd2, 32'd2, 3'd4);
    step();
    chk("bp_occ_hold", {30'b0, bus.occupancy}, 32'd2);
    chk("bp_head_res", bus.cdb_result, 32'd2);
    chk("bp_head_tag", {29'b0, bus.cdb_tag}, 32'd1);
    bus.cdb_grant = 1'b1;
    #1;
    chk("bp_ready_pop", {31'b0, bus.issue_ready}, 32'd1);
    step();
    chk("bp_occ_pp", {30'b0, bus.occupancy}, 32'd2);
    chk("bp_head2_res", bus.cdb_result, 32'd3);
    chk("bp_head2_tag", {29'b0, bus.cdb_tag}, 32'd2);
    bus.issue_valid = 1'b0;
    step();
    chk("bp_head3_res", bus.cdb_result, 32'd4);
    chk("bp_head3_tag", {29'b0, bus.cdb_tag}, 32'd4);
    chk("bp_occ3", {30'b0, bus.occupancy}, 32'd1);
    step();
    chk("bp_empty", {30'b0, bus.occupancy}, 32'd0);

    // Flush drops queue, same-cycle accept and pop
    bus.cdb_grant = 1'b0;
    drive(mk(OP, 3'b000, 1'b0), 32'd10, 32'd1, 3'd1);
    step();
    drive(mk(OP, 3'b000, 1'b0), 32'd20, 32'd2, 3'd2);
    step();
    chk("fl_pre_occ", {30'b0, bus.occupancy}, 32'd2);
    drive(mk(OP, 3'b000, 1'b0), 32'd30, 32'd3, 3'd3);
    bus.cdb_grant = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    chk("fl_occ", {30'b0, bus.occupancy}, 32'd0);
    chk("fl_valid", {31'b0, bus.cdb_valid}, 32'd0);
    step();
    chk("fl_no_ghost", {31'b0, bus.cdb_valid}, 32'd0);

    // Async reset with a full queue, then a fresh op
    bus.cdb_grant = 1'b0;
    drive(mk(OP, 3'b000, 1'b0), 32'd6, 32'd1, 3'd6);
    step();
    drive(mk(OP, 3'b000, 1'b0), 32'd8, 32'd1, 3'd7);
    step();
    bus.issue_valid = 1'b0;
    chk("ar_pre_occ", {30'b0, bus.occupancy}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, bus.cdb_valid}, 32'd0);
    chk("ar_occ", {30'b0, bus.occupancy}, 32'd0);
    chk("ar_result", bus.cdb_result, 32'd0);
    chk("ar_tag", {29'b0, bus.cdb_tag}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    bus.cdb_grant = 1'b1;
    drive(mk(OP, 3'b000, 1'b0), 32'd5, 32'd7, 3'd3);
    step();
    bus.issue_valid = 1'b0;
    chk("ar_op_valid", {31'b0, bus.cdb_valid}, 32'd1);
    chk("ar_op_res", bus.cdb_result, 32'd12);
    chk("ar_op_tag", {29'b0, bus.cdb_tag}, 32'd3);
    step();
    chk("ar_op_idle", {30'b0, bus.occupancy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_fu_pipe.md
Name: alu_fu_pipe

Overview:
- Parametrised, registered integer ALU functional unit for the out-of-order core; sits between the ALU reservation station and the common data bus (CDB) arbiter.
- Accepts one issued op per cycle through a valid/ready handshake and computes the RV32I LUI/AUIPC/OP-IMM/OP result.
- Buffers results in an output queue and holds each on the CDB until the arbiter grants it.
- Supports whole-unit flush on mispredict.

Parameters:
- ROB_DEPTH, 8, ROB entries; TAG_W = $clog2(ROB_DEPTH).
- XLEN, 32, datapath width; SH_W = $clog2(XLEN) shift-amount bits.
- OUT_DEPTH, 2, result queue entries (>=1); CNT_W = $clog2(OUT_DEPTH+1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  RS presents an op
- issue_ready  out  1  unit can accept this cycle
- issue_instr  in  32  raw instruction (opcode [6:0], funct3 [14:12], bit 30)
- issue_data_A  in  XLEN  operand A (rs1 or PC)
- issue_data_B  in  XLEN  operand B (rs2 or immediate)
- issue_tag  in  TAG_W  destination ROB tag
- flush  in  1  discard all in-flight results
- cdb_valid  out  1  queue head is valid
- cdb_grant  in  1  arbiter consumes head this cycle
- cdb_result  out  XLEN  head result
- cdb_tag  out  TAG_W  head ROB tag
- cdb_illegal  out  1  head came from an unsupported opcode/funct
- occupancy  out  CNT_W  queued result count

Behaviour:
- Reset (async, rst_n=0): queue empty, occupancy=0, cdb_valid=0, cdb_result=0, cdb_tag=0, cdb_illegal=0. issue_ready=1 once rst_n is released. Reset mid-operation drops all entries.
- Accept: issue_valid & issue_ready & !flush at a rising edge. The result is computed combinationally from the issue inputs and written to the queue tail at that edge.
- Latency: 1 cycle. An op accepted at edge N gives cdb_valid=1 after edge N if the queue was empty.
- Pop: cdb_valid & cdb_grant at an edge advances the head. Outputs hold stable while cdb_valid=1 and cdb_grant=0.
- issue_ready = (occupancy < OUT_DEPTH) | (cdb_valid & cdb_grant). A pop frees a slot for a same-cycle push. issue_ready does not depend on issue_valid.
- Simultaneous push and pop: occupancy unchanged. On a full queue, the push lands in the freed slot.
- Queue is circular with head/tail pointers that wrap at OUT_DEPTH-1 -> 0. When empty, cdb_result, cdb_tag and cdb_illegal read 0.
- Flush: synchronous, highest priority. It empties the queue and drops any same-cycle accept and pop. issue_ready is still computed normally during flush.
- Ops (A, B unsigned unless noted; all arithmetic mod 2^XLEN):
  - LUI: B.
  - AUIPC: A+B.
  - OP-IMM: add, sll, slt(signed), sltu, xor, srl/sra (bit30), or, and.
  - OP: same set, with add/sub selected by bit30.
  - Shifts use B[SH_W-1:0]. sra is arithmetic. slt/sltu return zero-extended 0/1.
- Illegal: any other opcode. The op is still accepted and queued with result 0, its tag, and cdb_illegal=1, so the ROB entry never hangs.
- No X is ever driven on outputs.

Optional Feature:
- Macro ALU_FU_BRANCH_EN.
- Defined: branch opcode (1100011) is legal. Result is a 0/1 taken flag from funct3:
  - beq, bne: equality of A, B.
  - blt, bge: signed compare.
  - bltu, bgeu: unsigned compare.
  - funct3 010/011 are illegal.
  - Adds port cdb_br_taken (out, 1), which equals the head result bit 0 and reads 0 when empty.
- Undefined: branch opcode follows the illegal path and the port is absent.

Test Plan:
- Reset then single op: OP add A=5, B=7, tag=3, cdb_grant=1 -> cdb_valid one cycle later with result 12, tag 3; then idle with occupancy=0.
- Arithmetic sweep: sub 3-5 -> 0xFFFFFFFE; sra 0x80000000>>4 -> 0xF8000000; srl of the same -> 0x08000000; slt -1<1 -> 1; sltu -1<1 -> 0; LUI B=0x12345000 -> 0x12345000; AUIPC A=0x100, B=0x2000 -> 0x2100.
- Backpressure: cdb_grant=0, issue 3 ops with OUT_DEPTH=2 -> issue_ready drops after 2 accepts; head held stable. Then grant plus a new issue in the same cycle -> accepted, occupancy stays 2, order preserved through pointer wrap.
- Flush: 2 queued entries, and flush asserted with issue_valid=1 and cdb_grant=1 -> next cycle occupancy=0, cdb_valid=0, the issued op never appears.
- Illegal opcode 0000011, tag 5 -> cdb_valid with result 0, tag 5, cdb_illegal=1. With ALU_FU_BRANCH_EN: bltu A=1, B=0xFFFFFFFF -> result 1, cdb_br_taken=1.
- Async reset asserted mid-cycle with a full queue -> outputs zero immediately without waiting for a clock edge; first op after release behaves as in scenario 1.
